// File: rtl/sbox_share_scheduler_if.sv
// rtl/sbox_share_scheduler_if.sv - requester, randomness and response bus of the shared S-box scheduler
interface sbox_share_scheduler_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_s0;
  logic [8*NREQ-1:0] req_s1;
  logic              rnd_valid;
  logic              rnd_ready;
  logic [7:0]        rnd_data;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_s0;
  logic [7:0]        rsp_s1;

  modport master (
    output req_valid, req_s0, req_s1, rnd_valid, rnd_data,
    input  req_ready, rnd_ready, rsp_valid, rsp_id, rsp_s0, rsp_s1
  );

  modport slave (
    input  req_valid, req_s0, req_s1, rnd_valid, rnd_data,
    output req_ready, rnd_ready, rsp_valid, rsp_id, rsp_s0, rsp_s1
  );
endinterface

// File: rtl/sbox_share_scheduler.sv
// rtl/sbox_share_scheduler.sv - round-robin sharing of one pipelined masked S-box between NREQ requesters
module sbox_share_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int LAT  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_en,
  sbox_share_scheduler_if.slave bus,
  output logic [7:0]          X_s0,
  output logic [7:0]          X_s1,
  output logic [7:0]          Fresh,
  input  logic [7:0]          Y_s0,
  input  logic [7:0]          Y_s1,
  output logic                busy,
  output logic [IDW+1:0]      inflight
);

  logic [IDW-1:0]           rr_q, rr_d;
  logic [7:0]               x_s0_q, x_s0_d;
  logic [7:0]               x_s1_q, x_s1_d;
  logic [7:0]               fresh_q, fresh_d;
  logic [LAT:0]             tag_v_q, tag_v_d;
  logic [LAT:0][IDW-1:0]    tag_id_q, tag_id_d;

  logic [NREQ-1:0]          grant;
  logic                     found;
  logic [IDW-1:0]           win_id;
  logic [IDW:0]             sum;
  logic [IDW:0]             nxt_rr;
  logic [7:0]               sel_s0;
  logic [7:0]               sel_s1;
  logic [IDW+1:0]           cnt;

  // Rotating priority search starting at the rr pointer.
  always_comb begin
    grant  = '0;
    found  = 1'b0;
    win_id = '0;
    sum    = '0;
    if (issue_en && bus.rnd_valid) begin
      for (int k = 0; k < NREQ; k++) begin
        sum = {1'b0, rr_q} + (IDW+1)'(k);
        if (sum >= (IDW+1)'(NREQ)) begin
          sum = sum - (IDW+1)'(NREQ);
        end
        if (!found && bus.req_valid[sum[IDW-1:0]]) begin
          found                = 1'b1;
          grant[sum[IDW-1:0]]  = 1'b1;
          win_id               = sum[IDW-1:0];
        end
      end
    end
  end

  always_comb begin
    sel_s0 = '0;
    sel_s1 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_s0 = bus.req_s0[8*i +: 8];
        sel_s1 = bus.req_s1[8*i +: 8];
      end
    end
    nxt_rr = {1'b0, win_id} + (IDW+1)'(1);
    if (nxt_rr >= (IDW+1)'(NREQ)) begin
      nxt_rr = '0;
    end
  end

  // Idle edges load zeros so stale shares never sit on the S-box inputs.
  always_comb begin
    rr_d        = found ? nxt_rr[IDW-1:0] : rr_q;
    x_s0_d      = found ? sel_s0 : 8'h00;
    x_s1_d      = found ? sel_s1 : 8'h00;
    fresh_d     = found ? bus.rnd_data : 8'h00;
    tag_v_d     = '0;
    tag_id_d    = '0;
    tag_v_d[0]  = found;
    tag_id_d[0] = found ? win_id : '0;
    for (int i = 1; i <= LAT; i++) begin
      tag_v_d[i]  = tag_v_q[i-1];
      tag_id_d[i] = tag_id_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q     <= '0;
      x_s0_q   <= '0;
      x_s1_q   <= '0;
      fresh_q  <= '0;
      tag_v_q  <= '0;
      tag_id_q <= '0;
    end else begin
      rr_q     <= rr_d;
      x_s0_q   <= x_s0_d;
      x_s1_q   <= x_s1_d;
      fresh_q  <= fresh_d;
      tag_v_q  <= tag_v_d;
      tag_id_q <= tag_id_d;
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i <= LAT; i++) begin
      cnt = cnt + (IDW+2)'(tag_v_q[i]);
    end
  end

  assign bus.req_ready = grant;
  assign bus.rnd_ready = found;
  assign X_s0          = x_s0_q;
  assign X_s1          = x_s1_q;
  assign Fresh         = fresh_q;
  // Last tag stage lines up with the S-box output of the same operation.
  assign bus.rsp_valid = tag_v_q[LAT];
  assign bus.rsp_id    = tag_id_q[LAT];
  assign bus.rsp_s0    = tag_v_q[LAT] ? Y_s0 : 8'h00;
  assign bus.rsp_s1    = tag_v_q[LAT] ? Y_s1 : 8'h00;
  assign busy          = |tag_v_q;
  assign inflight      = cnt;

endmodule

// File: tb/tb_sbox_share_scheduler.sv
// tb/tb_sbox_share_scheduler.sv - directed self-checking bench for sbox_share_scheduler
module tb_sbox_share_scheduler;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int LAT  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       issue_en = 1'b0;
  logic [7:0] X_s0, X_s1, Fresh, Y_s0, Y_s1;
  logic       busy;
  logic [3:0] inflight;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int max_inf;
  int rsp_t[$];
  logic [IDW-1:0] rsp_ids[$];
  logic [7:0] rsp_x[$];
  logic [7:0] sb_exp [4];

  sbox_share_scheduler_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  sbox_share_scheduler #(.NREQ(NREQ), .IDW(IDW), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .issue_en(issue_en), .bus(bus),
    .X_s0(X_s0), .X_s1(X_s1), .Fresh(Fresh), .Y_s0(Y_s0), .Y_s1(Y_s1),
    .busy(busy), .inflight(inflight)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int c = 1; c < 256; c++) begin
      if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Behavioural masked S-box: LAT register stages, output shares re-masked by Fresh.
  logic [7:0] p0 [LAT];
  logic [7:0] p1 [LAT];
  always @(posedge clk) begin
    p0[0] <= aes_sbox(X_s0 ^ X_s1) ^ Fresh;
    p1[0] <= Fresh;
    for (int i = 1; i < LAT; i++) begin
      p0[i] <= p0[i-1];
      p1[i] <= p1[i-1];
    end
  end
  assign Y_s0 = p0[LAT-1];
  assign Y_s1 = p1[LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rsp_valid) begin
      rsp_t.push_back(cyc);
      rsp_ids.push_back(bus.rsp_id);
      rsp_x.push_back(bus.rsp_s0 ^ bus.rsp_s1);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (int'(inflight) > max_inf) max_inf = int'(inflight);
  endtask

  task automatic clear_q();
    rsp_t.delete();
    rsp_ids.delete();
    rsp_x.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sb_exp[0] = 8'h63; sb_exp[1] = 8'h7C; sb_exp[2] = 8'h77; sb_exp[3] = 8'h7B;
    max_inf = 0;
    bus.req_valid = '0;
    bus.req_s0 = '0;
    bus.req_s1 = '0;
    bus.rnd_valid = 1'b0;
    bus.rnd_data = 8'h00;

    // Reset state
    #2 rst_n = 1'b0;
    #2;
    check_eq("rst_x_s0", X_s0, 8'h00);
    check_eq("rst_fresh", Fresh, 8'h00);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_inflight", inflight, 4'd0);
    check_eq("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check_eq("rst_rsp_id", bus.rsp_id, 2'd0);
    tick(); tick();
    rst_n = 1'b1;

    // Single request 0x53 -> S-box 0xED
    issue_en = 1'b1;
    bus.req_valid = 4'b0001;
    bus.req_s0 = 32'h000000A5;
    bus.req_s1 = 32'h000000F6;
    bus.rnd_valid = 1'b1;
    bus.rnd_data = 8'h11;
    #1;
    check_eq("single_grant", bus.req_ready, 4'b0001);
    check_eq("single_rnd_ready", bus.rnd_ready, 1'b1);
    tick();
    bus.req_valid = '0;
    check_eq("single_x_s0", X_s0, 8'hA5);
    check_eq("single_x_s1", X_s1, 8'hF6);
    check_eq("single_fresh", Fresh, 8'h11);
    check_eq("single_inflight", inflight, 4'd1);
    check_eq("single_rsp_e0", bus.rsp_valid, 1'b0);
    tick();
    check_eq("single_idle_x_s0", X_s0, 8'h00);
    check_eq("single_rsp_e1", bus.rsp_valid, 1'b0);
    tick();
    check_eq("single_rsp_e2", bus.rsp_valid, 1'b0);
    tick();
    check_eq("single_rsp_e3", bus.rsp_valid, 1'b1);
    check_eq("single_rsp_id", bus.rsp_id, 2'd0);
    check_eq("single_rsp_xor", bus.rsp_s0 ^ bus.rsp_s1, 8'hED);
    tick();
    check_eq("single_rsp_e4", bus.rsp_valid, 1'b0);
    check_eq("single_rsp_s0_zero", bus.rsp_s0, 8'h00);
    check_eq("single_busy_after", busy, 1'b0);

    // Fairness: all four requesting, pointer reset to 0 first
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    clear_q();
    max_inf = 0;
    bus.req_s0 = {8'h59, 8'h58, 8'h5B, 8'h5A};
    bus.req_s1 = {4{8'h5A}};
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      check_eq($sformatf("fair_grant%0d", k), bus.req_ready, 32'(1) << (k % 4));
      tick();
    end
    bus.req_valid = '0;
    for (int k = 0; k < 5; k++) tick();
    check_eq("fair_rsp_count", rsp_ids.size(), 8);
    if (rsp_ids.size() == 8) begin
      for (int j = 0; j < 8; j++) begin
        check_eq($sformatf("fair_rsp_id%0d", j), rsp_ids[j], j % 4);
        check_eq($sformatf("fair_rsp_xor%0d", j), rsp_x[j], sb_exp[j % 4]);
        check_eq($sformatf("fair_rsp_cyc%0d", j), rsp_t[j] - rsp_t[0], j);
      end
    end
    check_eq("fair_max_inflight", max_inf, 4);

    // Randomness starvation; pointer is back at 0
    clear_q();
    bus.req_valid = 4'b0100;
    bus.rnd_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq($sformatf("starve_ready%0d", k), {bus.req_ready, bus.rnd_ready}, 5'b0);
      tick();
    end
    check_eq("starve_idle_x_s0", X_s0, 8'h00);
    bus.rnd_valid = 1'b1;
    bus.rnd_data = 8'hC7;
    #1;
    check_eq("starve_grant", bus.req_ready, 4'b0100);
    tick();
    check_eq("starve_fresh", Fresh, 8'hC7);
    check_eq("starve_x_s0", X_s0, 8'h58);
    bus.req_valid = 4'b1111;
    #1;
    check_eq("starve_ptr3", bus.req_ready, 4'b1000);
    bus.req_valid = '0;
    for (int k = 0; k < 5; k++) tick();
    check_eq("starve_rsp_count", rsp_ids.size(), 1);

    // issue_en drop after three issues (pointer at 3 -> 3,0,1)
    clear_q();
    bus.req_valid = 4'b1111;
    #1;
    check_eq("ien_grant0", bus.req_ready, 4'b1000);
    tick();
    check_eq("ien_grant1", bus.req_ready, 4'b0001);
    tick();
    check_eq("ien_grant2", bus.req_ready, 4'b0010);
    tick();
    issue_en = 1'b0;
    #1;
    check_eq("ien_no_grant", {bus.req_ready, bus.rnd_ready}, 5'b0);
    tick();
    check_eq("ien_idle_x_s0", X_s0, 8'h00);
    check_eq("ien_idle_fresh", Fresh, 8'h00);
    tick(); tick();
    check_eq("ien_last_rsp", bus.rsp_valid, 1'b1);
    check_eq("ien_busy_last", busy, 1'b1);
    tick();
    check_eq("ien_busy_after", busy, 1'b0);
    check_eq("ien_rsp_count", rsp_ids.size(), 3);
    if (rsp_ids.size() == 3) begin
      check_eq("ien_rsp_id0", rsp_ids[0], 2'd3);
      check_eq("ien_rsp_id1", rsp_ids[1], 2'd0);
      check_eq("ien_rsp_id2", rsp_ids[2], 2'd1);
    end

    // Reset mid-flight (pointer at 2 -> grants 0 then 1)
    issue_en = 1'b1;
    bus.req_valid = 4'b0011;
    tick(); tick();
    bus.req_valid = '0;
    clear_q();
    check_eq("rmid_inflight_pre", inflight, 4'd2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rmid_x_s0", X_s0, 8'h00);
    check_eq("rmid_x_s1", X_s1, 8'h00);
    check_eq("rmid_fresh", Fresh, 8'h00);
    check_eq("rmid_busy", busy, 1'b0);
    check_eq("rmid_inflight", inflight, 4'd0);
    check_eq("rmid_rsp_valid", bus.rsp_valid, 1'b0);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    check_eq("rmid_no_rsp", rsp_ids.size(), 0);
    bus.req_valid = 4'b1111;
    #1;
    check_eq("rmid_ptr0", bus.req_ready, 4'b0001);
    bus.req_valid = '0;

    // Zero unmasked input
    clear_q();
    bus.req_s0 = 32'h0000003C;
    bus.req_s1 = 32'h0000003C;
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = '0;
    tick(); tick(); tick();
    check_eq("zero_rsp_valid", bus.rsp_valid, 1'b1);
    check_eq("zero_rsp_id", bus.rsp_id, 2'd0);
    check_eq("zero_rsp_xor", bus.rsp_s0 ^ bus.rsp_s1, 8'h63);
    tick();
    check_eq("zero_rsp_end", bus.rsp_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sbox_share_scheduler.md
Name: sbox_share_scheduler

Overview:
- Round-robin scheduler that shares one pipelined first-order masked AES S-box (GHPC, 2 shares, 8-bit, LAT register stages) between NREQ requesters.
- Each cycle it arbitrates among pending masked-byte requests and gates issue on fresh randomness being available.
- It drives the S-box share and Fresh inputs, tracks each in-flight operation with a tag pipeline aligned to S-box latency, and routes the masked result back with the requester ID.
- It sits between the AES round datapath lanes (requesters) and the S-box instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width, equal to ceil(log2(NREQ)).
- LAT, 3, S-box latency in clock edges from the X inputs to a valid Y.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_en  in  1  when 0, no new issue; in-flight operations still complete.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_ready  out  NREQ  one-hot grant; handshake completes on the edge where valid&ready.
- req_s0  in  8*NREQ  share 0 of the input byte; byte i belongs to requester i.
- req_s1  in  8*NREQ  share 1 of the input byte.
- rnd_valid  in  1  fresh 8-bit randomness available.
- rnd_ready  out  1  randomness consumed this edge.
- rnd_data  in  8  fresh randomness.
- X_s0  out  8  S-box share 0 input (registered).
- X_s1  out  8  S-box share 1 input (registered).
- Fresh  out  8  S-box fresh randomness (registered).
- Y_s0  in  8  S-box output share 0.
- Y_s1  in  8  S-box output share 1.
- rsp_valid  out  1  result valid this cycle; there is no backpressure.
- rsp_id  out  IDW  requester ID of the result.
- rsp_s0  out  8  result share 0 (equals Y_s0).
- rsp_s1  out  8  result share 1 (equals Y_s1).
- busy  out  1  at least one operation in flight.
- inflight  out  IDW+2  number of operations in flight (0..LAT+1).

Behaviour:
- Reset (async, rst_n=0): rr pointer=0; X_s0=X_s1=Fresh=0; all tag-valid bits=0; rsp_valid=0, rsp_id=0; busy=0, inflight=0. Y_s* is ignored until a tagged result arrives.
- Grant (combinational): when issue_en=1 and rnd_valid=1, grant the first i with req_valid[i]=1, searching from the rr pointer upward modulo NREQ. Otherwise no grant.
  - req_ready = grant one-hot.
  - rnd_ready = |grant.
  - At most one issue per cycle.
- Issue edge (grant present):
  - X_s0/X_s1 <= req_s0/req_s1 of the winner; Fresh <= rnd_data.
  - tag[0] <= {1, winner ID}.
  - rr pointer <= winner+1 mod NREQ.
- No-issue edge: X_s0, X_s1 and Fresh <= 0, so share values never persist or recombine across idle cycles; tag[0] valid <= 0; rr pointer holds.
- Tag pipeline: LAT-stage shift register that shifts every edge and never stalls.
- Result timing: a handshake at edge E gives X_s* visible after E, Y_s* visible after E+LAT, and rsp_valid=1 for exactly the one cycle following edge E+LAT.
  - rsp_id = tag ID; rsp_s* = Y_s* passthrough.
  - When rsp_valid=0, rsp_s0 and rsp_s1 are forced to 0.
- Back-to-back operation: issues on consecutive edges give responses on consecutive cycles in issue order, with full throughput of 1 byte/cycle.
- busy = OR of the issue-register valid bit and all tag-valid bits.
- inflight = popcount of those same valid bits.
- Toggling issue_en has no effect on in-flight operations.
- Simultaneous events:
  - A requester may be granted again on the edge its previous response appears; issue and response are independent.
  - rnd_valid=0 blocks all grants but does not move the pointer.
- A request held with req_valid=1 must keep req_s* stable until its handshake. The scheduler does not check this.
- Reset mid-operation: all tags cleared immediately, with no spurious rsp_valid after reset release. Results for those operations are lost.

Test Plan:
- Single request, NREQ=4, LAT=3: req_valid=0001, s0=0xA5, s1=0xF6 (unmasked 0x53), rnd_valid=1, handshake at edge 10 -> X_s0=0xA5 and X_s1=0xF6 after edge 10; rsp_valid only in the cycle after edge 13, rsp_id=0, rsp_s0^rsp_s1=0xED.
- Fairness: all four req_valid held high for 8 edges -> grant order 0,1,2,3,0,1,2,3; 8 responses on consecutive cycles with IDs in the same order; inflight peaks at 4.
- Randomness starvation: req_valid=0100, rnd_valid=0 for 5 edges then 1 -> req_ready=0 and rnd_ready=0 while starved; one issue after; Fresh equals the rnd_data sampled on that edge; pointer advances to 3.
- issue_en drop: 3 back-to-back issues, then issue_en=0 -> no new grants; 3 responses still delivered; busy falls after the last response; X_s* and Fresh are 0 on idle edges.
- Reset mid-flight: 2 operations issued, rst_n asserted asynchronously between edges -> all outputs 0 immediately; no rsp_valid within 6 edges after release; pointer restarts at 0 (req_valid=1111 grants ID 0 first).
- Zero input: shares 0x3C/0x3C (unmasked 0x00) -> rsp_s0^rsp_s1=0x63 after LAT+1 cycles.
